// File: rtl/sync_fifo_ctrl_if.sv
// Handshake and status bundle between a FIFO owner and sync_fifo_ctrl.
interface sync_fifo_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 41,
   parameter int unsigned ADDR_WIDTH = 4
);
   localparam int unsigned CNT_W = ADDR_WIDTH + 1;

   logic                  flush;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [CNT_W-1:0]      count;
   logic                  overflow;
   logic                  underflow;

   // Producer/consumer side: issues requests, observes data and status.
   modport master (
      output flush, wr_en, wr_data, rd_en,
      input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   // FIFO side: accepts requests, drives data and status.
   modport slave (
      input  flush, wr_en, wr_data, rd_en,
      output rd_data, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller for same-domain buffering of bridge packets.
// Occupancy count, programmable almost-full/almost-empty, standard or FWFT
// read path, synchronous flush and sticky overflow/underflow flags.
module sync_fifo_ctrl #(
   parameter int unsigned DATA_WIDTH = 41,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter bit          FWFT       = 1'b0,
   parameter int unsigned AF_THRESH  = (2**ADDR_WIDTH) - 2,
   parameter int unsigned AE_THRESH  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   sync_fifo_ctrl_if.slave   fifo
);

   localparam int unsigned DEPTH = 2**ADDR_WIDTH;
   localparam int unsigned PTR_W = ADDR_WIDTH + 1;
   localparam int unsigned CNT_W = ADDR_WIDTH + 1;
   localparam bit          AF_RST = (AF_THRESH == 0);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic             full_q,   full_d;
   logic             empty_q,  empty_d;
   logic             af_q,     af_d;
   logic             ae_q,     ae_d;
   logic             ovf_q,    ovf_d;
   logic             unf_q,    unf_d;

   logic             wr_fire_c;
   logic             rd_fire_c;

   logic [ADDR_WIDTH-1:0] wr_idx_c;
   logic [ADDR_WIDTH-1:0] rd_idx_c;

   assign wr_idx_c = wr_ptr_q[ADDR_WIDTH-1:0];
   assign rd_idx_c = rd_ptr_q[ADDR_WIDTH-1:0];

   // Accept decisions use the registered flags; flush blocks both sides.
   always_comb begin
      wr_fire_c = 1'b0;
      rd_fire_c = 1'b0;
      if (!fifo.flush) begin
         wr_fire_c = fifo.wr_en && !full_q;
         rd_fire_c = fifo.rd_en && !empty_q;
      end
   end

   // Next-state for pointers, occupancy, level flags and sticky errors.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      full_d   = full_q;
      empty_d  = empty_q;
      af_d     = af_q;
      ae_d     = ae_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;

      if (fifo.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         full_d   = 1'b0;
         empty_d  = 1'b1;
         af_d     = AF_RST;
         ae_d     = 1'b1;
         ovf_d    = 1'b0;
         unf_d    = 1'b0;
      end else begin
         if (wr_fire_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (rd_fire_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end

         unique case ({wr_fire_c, rd_fire_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase

         // Flags track the occupancy that will hold after this edge.
         full_d  = (count_d == CNT_W'(DEPTH));
         empty_d = (count_d == '0);
         af_d    = (32'(count_d) >= AF_THRESH);
         ae_d    = (32'(count_d) <= AE_THRESH);

         if (fifo.wr_en && full_q) begin
            ovf_d = 1'b1;
         end
         if (fifo.rd_en && empty_q) begin
            unf_d = 1'b1;
         end
      end
   end

   // Control state register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         af_q     <= AF_RST;
         ae_q     <= 1'b1;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         af_q     <= af_d;
         ae_q     <= ae_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Storage array; contents survive reset and flush.
   always_ff @(posedge clk) begin
      if (rst_n && wr_fire_c) begin
         mem_q[wr_idx_c] <= fifo.wr_data;
      end
   end

   generate
      if (FWFT) begin : g_fwft_read
         // Head word is presented directly; zero while nothing is stored.
         always_comb begin
            fifo.rd_data  = '0;
            fifo.rd_valid = !empty_q;
            if (!empty_q) begin
               fifo.rd_data = mem_q[rd_idx_c];
            end
         end
      end else begin : g_std_read
         logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
         logic                  rd_valid_q, rd_valid_d;

         // Accepted read captures the head word; data holds otherwise.
         always_comb begin
            rd_data_d  = rd_data_q;
            rd_valid_d = rd_fire_c;
            if (rd_fire_c) begin
               rd_data_d = mem_q[rd_idx_c];
            end
         end

         // Read output register; reset clears data, flush only clears valid.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               rd_data_q  <= '0;
               rd_valid_q <= 1'b0;
            end else begin
               rd_data_q  <= rd_data_d;
               rd_valid_q <= rd_valid_d;
            end
         end

         assign fifo.rd_data  = rd_data_q;
         assign fifo.rd_valid = rd_valid_q;
      end
   endgenerate

   assign fifo.count        = count_q;
   assign fifo.full         = full_q;
   assign fifo.empty        = empty_q;
   assign fifo.almost_full  = af_q;
   assign fifo.almost_empty = ae_q;
   assign fifo.overflow     = ovf_q;
   assign fifo.underflow    = unf_q;

endmodule
